ila_trace_arbiter: RTL and testbench
====================================

# ila_trace_arbiter

Merges the two per-hart ILA commit-trace streams (ila_0_*, ila_1_*) from the PARD FPGA top into one valid/ready trace port for a single capture sink (ILA core or trace DMA). Each hart gets a small FIFO because cores cannot be stalled. A round-robin arbiter drains the FIFOs into a registered output stage. Overflow drops records and counts them per hart. The block sits in the uncore clock domain beside rocketchip_top.

## Interface
Parameters:
- DEPTH, 4: entries per hart FIFO; power of two, 2..16.
- CNT_W, 32: width of each drop counter.

Ports:
- uncoreclk  in  1  sole clock; all state on rising edge.
- uncorerst_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; when 0, no record is enqueued and nothing is counted as dropped.
- clear_drops  in  1  single-cycle pulse; zeroes both drop counters.
- in{h}_valid  in  1  commit valid for hart h (h = 0, 1).
- in{h}_hartid  in  2  hart id.
- in{h}_pc  in  40  commit PC.
- in{h}_instr  in  32  instruction word.
- in{h}_rd_wen  in  1  register write enable.
- in{h}_rd_waddr  in  5  destination register.
- in{h}_rd_wdata  in  64  write data.
- out_valid  out  1  output record valid.
- out_ready  in  1  sink accepts the record.
- out_src  out  1  index of the hart FIFO the record came from.
- out_hartid, out_pc, out_instr, out_rd_wen, out_rd_waddr, out_rd_wdata  out  2/40/32/1/5/64  record fields.
- out_seq  out  16  emitted-record sequence number; wraps 0xFFFF -> 0x0000.
- drops0, drops1  out  CNT_W  per-hart saturating drop counters.

## Operation
- A record is the 144-bit concatenation {hartid, pc, instr, rd_wen, rd_waddr, rd_wdata}. It is stored unchanged.
- Push for hart h: in{h}_valid & enable.
  - Accepted if count_h < DEPTH, or if count_h == DEPTH and the same FIFO pops in this cycle.
  - Otherwise the record is dropped and drops_h increments.
- Drop counter rules:
  - drops_h saturates at all-ones.
  - clear_drops in the same cycle as a drop loads the counter with 1.
  - clear_drops alone loads 0.
- Output stage (out_valid plus fields) loads when (!out_valid | out_ready) and at least one FIFO is non-empty. The chosen FIFO pops in that same cycle.
- Arbiter register last_src:
  - Both FIFOs non-empty: grant ~last_src.
  - One FIFO non-empty: grant that one.
  - On each load, last_src <= granted index.
- out_seq increments by 1 on every out_valid & out_ready handshake.
- enable = 0 does not flush anything. Buffered records continue to drain.

## Timing
- Reset values:
  - FIFOs empty.
  - out_valid = 0; all out_* record fields = 0; out_src = 0.
  - out_seq = 0; drops0 = drops1 = 0.
  - last_src = 1, so hart 0 wins the first tie.
- Minimum latency:
  - Push in cycle N makes the FIFO non-empty in N+1.
  - The output register loads at the end of N+1; out_valid is seen in N+2.
- Throughput: one record per cycle while out_ready stays high. Total ingress of 2 records/cycle is sustained only up to the buffer depth.
- Handshake:
  - out_* fields are stable while out_valid & !out_ready.
  - out_valid does not drop without a handshake.
- Pointers: FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full means count == DEPTH; empty means count == 0.
- Async reset mid-operation discards every buffered record and the output record immediately. No handshake completes in the reset cycle.

## Test plan
- Reset, then one push from hart 0 (pc=0x80000000, instr=0x00000013) with out_ready=1: out_valid rises exactly 2 cycles later with matching fields, out_src=0, out_seq=0. It stays valid 1 cycle.
- Both harts push every cycle for 3 cycles with out_ready=1: output alternates src 0,1,0,1,0,1; drops0 = drops1 = 0; out_seq ends at 6 after the final handshake.
- out_ready=0; hart 0 pushes 8 records with DEPTH=4: 4 are buffered and 1 is held in the output stage; drops0=3. Then out_ready=1: the 5 survivors drain in order.
- FIFO full; a push coincides with a pop: no drop, and count stays DEPTH.
- drops1 preset to 0xFFFFFFFF by forcing overflows: further drops hold the value. clear_drops together with a drop gives 1.
- Assert uncorerst_n low with 3 records buffered and out_valid=1: outputs read reset values immediately. After release, no stale record emerges.

Source files
------------

// File: rtl/ila_trace_arbiter.sv
// Merges two per-hart ILA commit-trace streams into one valid/ready port.
// Each hart has a drop-on-overflow FIFO; a round-robin arbiter feeds a registered output stage.

module ila_trace_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32,
    parameter int REC_W = 144
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req,
    input  logic             pop,
    input  logic             clear,
    input  logic [REC_W-1:0] din,
    output logic [REC_W-1:0] head,
    output logic             not_empty,
    output logic [CNT_W-1:0] drops
);
    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr, count;
    logic             accept, drop;

    assign count     = wptr - rptr;
    assign not_empty = (count != '0);
    assign head      = mem[rptr[AW-1:0]];
    // A full FIFO still takes the record when the arbiter drains it in the same cycle.
    assign accept    = push_req & ((count != (AW+1)'(DEPTH)) | pop);
    assign drop      = push_req & ~accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (accept) wptr <= wptr + (AW+1)'(1);
            if (pop)    rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wptr[AW-1:0]] <= din;
    end

    // Saturating counter; a clear coinciding with a drop still records that drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    drops <= '0;
        else if (clear)                drops <= drop ? CNT_W'(1) : '0;
        else if (drop && drops != '1)  drops <= drops + CNT_W'(1);
    end
endmodule

module ila_trace_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             uncoreclk,
    input  logic             uncorerst_n,
    input  logic             enable,
    input  logic             clear_drops,
    input  logic             in0_valid,
    input  logic [1:0]       in0_hartid,
    input  logic [39:0]      in0_pc,
    input  logic [31:0]      in0_instr,
    input  logic             in0_rd_wen,
    input  logic [4:0]       in0_rd_waddr,
    input  logic [63:0]      in0_rd_wdata,
    input  logic             in1_valid,
    input  logic [1:0]       in1_hartid,
    input  logic [39:0]      in1_pc,
    input  logic [31:0]      in1_instr,
    input  logic             in1_rd_wen,
    input  logic [4:0]       in1_rd_waddr,
    input  logic [63:0]      in1_rd_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic [1:0]       out_hartid,
    output logic [39:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic             out_rd_wen,
    output logic [4:0]       out_rd_waddr,
    output logic [63:0]      out_rd_wdata,
    output logic [15:0]      out_seq,
    output logic [CNT_W-1:0] drops0,
    output logic [CNT_W-1:0] drops1
);
    typedef struct packed {
        logic [1:0]  hartid;
        logic [39:0] pc;
        logic [31:0] instr;
        logic        rd_wen;
        logic [4:0]  rd_waddr;
        logic [63:0] rd_wdata;
    } trace_rec_t;

    trace_rec_t [1:0]            in_rec, head_rec;
    trace_rec_t                  out_rec;
    logic [1:0]                  push_req, pop, not_empty;
    logic [1:0][CNT_W-1:0]       drops;
    logic                        load, grant, last_src;

    assign in_rec[0] = {in0_hartid, in0_pc, in0_instr, in0_rd_wen, in0_rd_waddr, in0_rd_wdata};
    assign in_rec[1] = {in1_hartid, in1_pc, in1_instr, in1_rd_wen, in1_rd_waddr, in1_rd_wdata};
    assign push_req  = {in1_valid & enable, in0_valid & enable};

    for (genvar h = 0; h < 2; h++) begin : g_hart
        ila_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .REC_W($bits(trace_rec_t))) u_fifo (
            .clk       (uncoreclk),
            .rst_n     (uncorerst_n),
            .push_req  (push_req[h]),
            .pop       (pop[h]),
            .clear     (clear_drops),
            .din       (in_rec[h]),
            .head      (head_rec[h]),
            .not_empty (not_empty[h]),
            .drops     (drops[h])
        );
    end

    assign load = (~out_valid | out_ready) & (|not_empty);

    always_comb begin
        grant = not_empty[1];
        if (&not_empty) grant = ~last_src;
    end

    assign pop = load ? (grant ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge uncoreclk or negedge uncorerst_n) begin
        if (!uncorerst_n) begin
            out_valid <= 1'b0;
            out_rec   <= '0;
            out_src   <= 1'b0;
            last_src  <= 1'b1;
            out_seq   <= '0;
        end else begin
            if (out_valid & out_ready) out_seq <= out_seq + 16'd1;
            if (load) begin
                out_valid <= 1'b1;
                out_rec   <= head_rec[grant];
                out_src   <= grant;
                last_src  <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_hartid   = out_rec.hartid;
    assign out_pc       = out_rec.pc;
    assign out_instr    = out_rec.instr;
    assign out_rd_wen   = out_rec.rd_wen;
    assign out_rd_waddr = out_rec.rd_waddr;
    assign out_rd_wdata = out_rec.rd_wdata;
    assign drops0       = drops[0];
    assign drops1       = drops[1];
endmodule

// File: tb/tb_ila_trace_arbiter.sv
// Bench for ila_trace_arbiter: vector table, hand-written corner sequences, and a
// randomized run against a queue-based reference model.

module tb_ila_trace_arbiter;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] SAT = '1;

    logic uncoreclk = 1'b0;
    logic uncorerst_n = 1'b0;
    logic enable, clear_drops, out_ready;
    logic in0_valid, in1_valid, in0_rd_wen, in1_rd_wen;
    logic [1:0] in0_hartid, in1_hartid, out_hartid;
    logic [39:0] in0_pc, in1_pc, out_pc;
    logic [31:0] in0_instr, in1_instr, out_instr;
    logic [4:0] in0_rd_waddr, in1_rd_waddr, out_rd_waddr;
    logic [63:0] in0_rd_wdata, in1_rd_wdata, out_rd_wdata;
    logic out_valid, out_src, out_rd_wen;
    logic [15:0] out_seq;
    logic [CNT_W-1:0] drops0, drops1;
    logic [143:0] out_rec;

    ila_trace_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .uncoreclk(uncoreclk), .uncorerst_n(uncorerst_n), .enable(enable), .clear_drops(clear_drops),
        .in0_valid(in0_valid), .in0_hartid(in0_hartid), .in0_pc(in0_pc), .in0_instr(in0_instr),
        .in0_rd_wen(in0_rd_wen), .in0_rd_waddr(in0_rd_waddr), .in0_rd_wdata(in0_rd_wdata),
        .in1_valid(in1_valid), .in1_hartid(in1_hartid), .in1_pc(in1_pc), .in1_instr(in1_instr),
        .in1_rd_wen(in1_rd_wen), .in1_rd_waddr(in1_rd_waddr), .in1_rd_wdata(in1_rd_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_hartid(out_hartid),
        .out_pc(out_pc), .out_instr(out_instr), .out_rd_wen(out_rd_wen), .out_rd_waddr(out_rd_waddr),
        .out_rd_wdata(out_rd_wdata), .out_seq(out_seq), .drops0(drops0), .drops1(drops1)
    );

    assign out_rec = {out_hartid, out_pc, out_instr, out_rd_wen, out_rd_waddr, out_rd_wdata};

    always #5 uncoreclk = ~uncoreclk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [143:0] q0[$], q1[$];
    bit m_valid, m_src, m_last;
    logic [143:0] m_rec;
    logic [15:0] m_seq;
    logic [CNT_W-1:0] m_drops[2];

    typedef struct {
        bit rst; bit v0; bit v1;
        logic [39:0] pc0; logic [39:0] pc1; logic [31:0] ins0;
        bit rdy;
        bit ev; bit es; logic [39:0] epc; logic [31:0] eins; logic [15:0] eseq;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [143:0] mk(input logic [1:0] hid, input logic [39:0] pc, input logic [31:0] ins);
        return {hid, pc, ins, 1'b1, 5'd7, {24'h0, pc}};
    endfunction

    task automatic drive(input bit h, input logic v, input logic [143:0] r);
        if (h == 1'b0) begin
            in0_valid = v;
            {in0_hartid, in0_pc, in0_instr, in0_rd_wen, in0_rd_waddr, in0_rd_wdata} = r;
        end else begin
            in1_valid = v;
            {in1_hartid, in1_pc, in1_instr, in1_rd_wen, in1_rd_waddr, in1_rd_wdata} = r;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        clear_drops = 1'b0;
    endtask

    task automatic tick();
        @(posedge uncoreclk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        uncorerst_n = 1'b0;
        tick();
        tick();
        uncorerst_n = 1'b1;
        q0.delete(); q1.delete();
        m_valid = 0; m_src = 0; m_last = 1; m_rec = '0; m_seq = '0;
        m_drops[0] = '0; m_drops[1] = '0;
    endtask

    // One clock of the model, from the current inputs and pre-edge state.
    task automatic model_step();
        int s0, s1;
        bit ld, g, p0, p1, a0, a1, d0, d1, rq0, rq1;
        s0 = q0.size(); s1 = q1.size();
        ld = (!m_valid || out_ready) && (s0 > 0 || s1 > 0);
        g  = (s0 > 0 && s1 > 0) ? !m_last : (s1 > 0);
        p0 = ld && !g; p1 = ld && g;
        if (m_valid && out_ready) m_seq++;
        if (ld) begin
            m_rec = g ? q1.pop_front() : q0.pop_front();
            m_valid = 1; m_src = g; m_last = g;
        end else if (out_ready) m_valid = 0;
        rq0 = in0_valid && enable; rq1 = in1_valid && enable;
        a0 = rq0 && (s0 < DEPTH || p0);
        a1 = rq1 && (s1 < DEPTH || p1);
        d0 = rq0 && !a0; d1 = rq1 && !a1;
        if (a0) q0.push_back({in0_hartid, in0_pc, in0_instr, in0_rd_wen, in0_rd_waddr, in0_rd_wdata});
        if (a1) q1.push_back({in1_hartid, in1_pc, in1_instr, in1_rd_wen, in1_rd_waddr, in1_rd_wdata});
        if (clear_drops) begin
            m_drops[0] = d0 ? CNT_W'(1) : '0;
            m_drops[1] = d1 ? CNT_W'(1) : '0;
        end else begin
            if (d0 && m_drops[0] != SAT) m_drops[0]++;
            if (d1 && m_drops[1] != SAT) m_drops[1]++;
        end
    endtask

    initial begin
        enable = 1'b1;
        out_ready = 1'b0;
        idle();

        //          rst v0 v1 pc0            pc1       ins0           rdy ev es epc            eins           eseq
        tbl[0]  = '{1, 1, 0, 40'h80000000, 40'h0,   32'h00000013, 1, 0, 0, 40'h0,        32'h0,         16'd0};
        tbl[1]  = '{0, 0, 0, 40'h0,        40'h0,   32'h0,        1, 1, 0, 40'h80000000, 32'h00000013,  16'd0};
        tbl[2]  = '{0, 0, 0, 40'h0,        40'h0,   32'h0,        1, 0, 0, 40'h0,        32'h0,         16'd1};
        tbl[3]  = '{1, 1, 1, 40'h100,      40'h200, 32'h100,      1, 0, 0, 40'h0,        32'h0,         16'd0};
        tbl[4]  = '{0, 1, 1, 40'h101,      40'h201, 32'h101,      1, 1, 0, 40'h100,      32'h100,       16'd0};
        tbl[5]  = '{0, 1, 1, 40'h102,      40'h202, 32'h102,      1, 1, 1, 40'h200,      32'h200,       16'd1};
        tbl[6]  = '{0, 0, 0, 40'h0,        40'h0,   32'h0,        1, 1, 0, 40'h101,      32'h101,       16'd2};
        tbl[7]  = '{0, 0, 0, 40'h0,        40'h0,   32'h0,        1, 1, 1, 40'h201,      32'h201,       16'd3};
        tbl[8]  = '{0, 0, 0, 40'h0,        40'h0,   32'h0,        1, 1, 0, 40'h102,      32'h102,       16'd4};
        tbl[9]  = '{0, 0, 0, 40'h0,        40'h0,   32'h0,        1, 1, 1, 40'h202,      32'h202,       16'd5};
        tbl[10] = '{0, 0, 0, 40'h0,        40'h0,   32'h0,        1, 0, 0, 40'h0,        32'h0,         16'd6};

        // reset state
        tick();
        check("reset out_valid", out_valid, 0);
        check("reset out_rec", out_rec, 0);
        check("reset out_seq", out_seq, 0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) do_reset();
            drive(1'b0, tbl[i].v0, mk(2'd0, tbl[i].pc0, tbl[i].ins0));
            drive(1'b1, tbl[i].v1, mk(2'd1, tbl[i].pc1, tbl[i].pc1[31:0]));
            out_ready = tbl[i].rdy;
            tick();
            check($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                check($sformatf("vec%0d out_src", i), out_src, tbl[i].es);
                check($sformatf("vec%0d out_pc", i), out_pc, tbl[i].epc);
                check($sformatf("vec%0d out_instr", i), out_instr, tbl[i].eins);
            end
            check($sformatf("vec%0d out_seq", i), out_seq, tbl[i].eseq);
            check($sformatf("vec%0d drops", i), {drops1, drops0}, 0);
        end

        // overflow with stalled sink, then full FIFO push coinciding with pop
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, mk(2'd0, 40'h300 + 40'(i), 32'h0));
            tick();
        end
        idle();
        tick();
        check("ovf drops0", drops0, 3);
        check("ovf held pc", out_pc, 40'h300);
        out_ready = 1'b1;
        drive(1'b0, 1'b1, mk(2'd0, 40'h3F0, 32'h0));
        tick();
        check("full push+pop drops0", drops0, 3);
        check("full push+pop pc", out_pc, 40'h301);
        out_ready = 1'b0;
        drive(1'b0, 1'b1, mk(2'd0, 40'h3F1, 32'h0));
        tick();
        check("still full drops0", drops0, 4);
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("drain%0d valid", i), out_valid, 1);
            check($sformatf("drain%0d pc", i), out_pc, (i == 3) ? 40'h3F0 : 40'h302 + 40'(i));
        end
        tick();
        check("drain end valid", out_valid, 0);

        // drop counter saturation and clear interplay
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 22; i++) begin
            drive(1'b1, 1'b1, mk(2'd1, 40'h400 + 40'(i), 32'h0));
            tick();
        end
        check("sat drops1", drops1, SAT);
        check("sat drops0", drops0, 0);
        tick();
        check("sat hold drops1", drops1, SAT);
        clear_drops = 1'b1;
        tick();
        check("clear+drop drops1", drops1, 1);
        drive(1'b1, 1'b0, '0);
        tick();
        check("clear alone drops1", drops1, 0);
        idle();

        // randomized run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int phase;
            phase = c / 500;
            enable = ($urandom_range(0, 7) != 0);
            out_ready = (phase % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clear_drops = ($urandom_range(0, 60) == 0);
            drive(1'b0, $urandom_range(0, 1), {$urandom, $urandom, $urandom, $urandom, $urandom}[143:0]);
            drive(1'b1, $urandom_range(0, 1), {$urandom, $urandom, $urandom, $urandom, $urandom}[143:0]);
            model_step();
            tick();
            check("rnd out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("rnd out_src", out_src, m_src);
                check("rnd out_rec", out_rec, m_rec);
            end
            check("rnd out_seq", out_seq, m_seq);
            check("rnd drops0", drops0, m_drops[0]);
            check("rnd drops1", drops1, m_drops[1]);
        end
        idle();
        enable = 1'b1;

        // async reset mid-operation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, mk(2'd0, 40'h500 + 40'(i), 32'h0));
            tick();
        end
        idle();
        repeat (3) tick();
        check("pre-reset seq", out_seq, 2);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, mk(2'd0, 40'h510 + 40'(i), 32'h5));
            tick();
        end
        idle();
        tick();
        check("pre-reset valid", out_valid, 1);
        check("pre-reset pc", out_pc, 40'h510);
        #2 uncorerst_n = 1'b0;
        #1;
        check("async rst valid", out_valid, 0);
        check("async rst rec", out_rec, 0);
        check("async rst src", out_src, 0);
        check("async rst seq", out_seq, 0);
        tick();
        tick();
        uncorerst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("post-rst%0d valid", i), out_valid, 0);
        end
        check("post-rst seq", out_seq, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
